// File: rtl/skitter_pkg.sv
// Shared definitions for the skitter tap-word generator.
//   NTAP, CODE_BASE : delay-line geometry (tap count, code of the first set tap)
//   state_t         : controller states
//   therm_decode    : position code -> thermometer tap word
package skitter_pkg;

    localparam int NTAP      = 22;
    localparam int CODE_BASE = 17;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_SWEEP  = 2'd2
    } state_t;

    // Number of set taps is code - CODE_BASE + 1, clamped to 0..NTAP.
    function automatic logic [NTAP-1:0] therm_decode(input int code);
        int              m;
        logic [NTAP-1:0] word;
        m = code - CODE_BASE + 1;
        if (m < 0) begin
            m = 0;
        end else if (m > NTAP) begin
            m = NTAP;
        end
        for (int k = 0; k < NTAP; k++) begin
            word[k] = (k < m);
        end
        return word;
    endfunction

endpackage

// File: rtl/skitter_code_fifo.sv
// Position-code input queue for the tap-word generator.
// Synchronous FIFO, count-based full/empty, head word presented on dout.
//   clk, rst   : clock, asynchronous active-high reset (empties the queue)
//   push, din  : write strobe and data (ignored when full)
//   pop, dout  : read strobe (ignored when empty) and head-of-queue data
//   full, empty: occupancy flags
module skitter_code_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/skitter_tap_gen.sv
// Synthetic tap-word generator: rebuilds the delay-line thermometer word from
// streamed position codes or from an internal triangle sweep.
//   clk, rst          : clock, asynchronous active-high reset
//   start, stop, mode : control pulses; mode 0 = stream, 1 = sweep
//   pos_in/valid/ready: stream input handshake
//   sweep_lo/hi/dwell : sweep limits and extra hold cycles per code
//   qout, q_valid     : tap word and new-word strobe (registered)
//   bout              : last-tap indicator, qout[NTAP-1]
//   busy, ovf         : not idle; sticky write-while-full flag
// Build option: SKITTER_JITTER_EN adds LFSR-driven +/-1 code jitter.
//
// state     | meaning
// ST_IDLE   | no output words; queue still accepts writes
// ST_STREAM | pop one queued code per cycle; stop drains queue first
// ST_SWEEP  | triangle sweep sweep_lo..sweep_hi, each code dwell+1 cycles
module skitter_tap_gen #(
    parameter int NTAP       = skitter_pkg::NTAP,
    parameter int CODE_BASE  = skitter_pkg::CODE_BASE,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic            mode,
    input  logic [5:0]      pos_in,
    input  logic            pos_valid,
    output logic            pos_ready,
    input  logic [5:0]      sweep_lo,
    input  logic [5:0]      sweep_hi,
    input  logic [3:0]      sweep_dwell,
    output logic [NTAP-1:0] qout,
    output logic            q_valid,
    output logic            bout,
    output logic            busy,
    output logic            ovf
);
    import skitter_pkg::*;

    state_t          state_q, state_d;
    logic            drain_q, drain_d;
    logic [5:0]      cur_q, cur_d;
    logic            dir_up_q, dir_up_d;
    logic [5:0]      lo_q, lo_d;
    logic [5:0]      hi_q, hi_d;
    logic [3:0]      dwell_q, dwell_d;
    logic [3:0]      dwell_cnt_q, dwell_cnt_d;
    logic            emit;
    logic [5:0]      emit_code;
    logic            pop;
    logic            push;
    logic [5:0]      fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;
    int              dec_code;
    logic [NTAP-1:0] word_d;

    assign pos_ready = !fifo_full;
    assign push      = pos_valid && !fifo_full && (state_q != ST_SWEEP);
    assign busy      = (state_q != ST_IDLE);
    assign bout      = qout[NTAP-1];

    skitter_code_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(6)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (pos_in),
        .pop  (pop),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        cur_d       = cur_q;
        dir_up_d    = dir_up_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        dwell_d     = dwell_q;
        dwell_cnt_d = dwell_cnt_q;
        emit        = 1'b0;
        emit_code   = cur_q;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                drain_d = 1'b0;
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start && mode) begin
                    // First sweep word goes out on the same edge that leaves IDLE.
                    state_d     = ST_SWEEP;
                    lo_d        = sweep_lo;
                    hi_d        = sweep_hi;
                    dwell_d     = sweep_dwell;
                    cur_d       = sweep_lo;
                    dir_up_d    = 1'b1;
                    dwell_cnt_d = sweep_dwell;
                    emit        = 1'b1;
                    emit_code   = sweep_lo;
                end else if (start) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (stop) drain_d = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    emit      = 1'b1;
                    emit_code = fifo_dout;
                end else if (drain_q || stop) begin
                    state_d = ST_IDLE;
                    drain_d = 1'b0;
                end
            end
            ST_SWEEP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    emit = 1'b1;
                    if (dwell_cnt_q != 4'd0) begin
                        dwell_cnt_d = dwell_cnt_q - 4'd1;
                    end else begin
                        dwell_cnt_d = dwell_q;
                        // Turn at the end codes so each is emitted once per pass.
                        if (lo_q >= hi_q) begin
                            cur_d = cur_q;
                        end else if (dir_up_q) begin
                            if (cur_q == hi_q) begin
                                cur_d    = cur_q - 6'd1;
                                dir_up_d = 1'b0;
                            end else begin
                                cur_d = cur_q + 6'd1;
                            end
                        end else begin
                            if (cur_q == lo_q) begin
                                cur_d    = cur_q + 6'd1;
                                dir_up_d = 1'b1;
                            end else begin
                                cur_d = cur_q - 6'd1;
                            end
                        end
                        emit_code = cur_d;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef SKITTER_JITTER_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
        end else if (emit) begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_comb begin
        dec_code = int'(emit_code);
        case (lfsr_q[1:0])
            2'b00:   dec_code = dec_code - 1;
            2'b11:   dec_code = dec_code + 1;
            default: dec_code = dec_code;
        endcase
        if (dec_code < CODE_BASE - 1) begin
            dec_code = CODE_BASE - 1;
        end else if (dec_code > CODE_BASE + NTAP) begin
            dec_code = CODE_BASE + NTAP;
        end
        word_d = therm_decode(dec_code);
    end
`else
    always_comb begin
        dec_code = int'(emit_code);
        word_d   = therm_decode(dec_code);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            drain_q     <= 1'b0;
            cur_q       <= '0;
            dir_up_q    <= 1'b1;
            lo_q        <= '0;
            hi_q        <= '0;
            dwell_q     <= '0;
            dwell_cnt_q <= '0;
            qout        <= '0;
            q_valid     <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            cur_q       <= cur_d;
            dir_up_q    <= dir_up_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            dwell_q     <= dwell_d;
            dwell_cnt_q <= dwell_cnt_d;
            q_valid     <= emit;
            if (emit) qout <= word_d;
            if (pos_valid && fifo_full) ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_skitter_tap_gen.sv
module tb_skitter_tap_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mode = 1'b0;
    logic [5:0]  pos_in = '0;
    logic        pos_valid = 1'b0;
    logic        pos_ready;
    logic [5:0]  sweep_lo = '0;
    logic [5:0]  sweep_hi = '0;
    logic [3:0]  sweep_dwell = '0;
    logic [21:0] qout;
    logic        q_valid;
    logic        bout;
    logic        busy;
    logic        ovf;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [21:0] exp_q[$];
    logic [7:0]  tb_lfsr = 8'hA5;

    always #5 clk = ~clk;

    skitter_tap_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .pos_in     (pos_in),
        .pos_valid  (pos_valid),
        .pos_ready  (pos_ready),
        .sweep_lo   (sweep_lo),
        .sweep_hi   (sweep_hi),
        .sweep_dwell(sweep_dwell),
        .qout       (qout),
        .q_valid    (q_valid),
        .bout       (bout),
        .busy       (busy),
        .ovf        (ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decode: m = c - 16 set taps, clamped to 0..22.
    function automatic logic [21:0] model_word(input int c);
        int          m;
        logic [22:0] t;
        m = c - 16;
        if (m < 0) m = 0;
        if (m > 22) m = 22;
        t = (23'd1 << m) - 23'd1;
        return t[21:0];
    endfunction

    function automatic int jit(input int c);
        int v;
        case (tb_lfsr[1:0])
            2'b00:   v = c - 1;
            2'b11:   v = c + 1;
            default: v = c;
        endcase
        tb_lfsr = {tb_lfsr[6:0], tb_lfsr[7] ^ tb_lfsr[5] ^ tb_lfsr[4] ^ tb_lfsr[3]};
        if (v < 16) v = 16;
        if (v > 39) v = 39;
        return v;
    endfunction

    // Expected word for the next emitted code, in emission order.
    function automatic logic [21:0] expect_word(input int c);
`ifdef SKITTER_JITTER_EN
        return model_word(jit(c));
`else
        return model_word(c);
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tb_lfsr = 8'hA5;
        tick();
        n_checks++; if (qout !== 22'h0) $display("FAIL reset_qout: got %h expected %h", qout, 22'h0); else n_pass++;
        n_checks++; if (q_valid !== 1'b0) $display("FAIL reset_q_valid: got %b expected 0", q_valid); else n_pass++;
        n_checks++; if (bout !== 1'b0) $display("FAIL reset_bout: got %b expected 0", bout); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf); else n_pass++;
        n_checks++; if (pos_ready !== 1'b1) $display("FAIL reset_pos_ready: got %b expected 1", pos_ready); else n_pass++;
    endtask

    task automatic test_decode();
        int          codes[5] = '{16, 17, 27, 38, 40};
        logic [21:0] words[5] = '{22'h000000, 22'h000001, 22'h0007FF, 22'h3FFFFF, 22'h3FFFFF};
        logic [21:0] e;
        e = '0;
        mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL decode_busy: got %b expected 1", busy); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            pos_in = 6'(codes[i]);
            pos_valid = 1'b1;
`ifdef SKITTER_JITTER_EN
            exp_q.push_back(expect_word(codes[i]));
`else
            exp_q.push_back(words[i]);
`endif
            tick();
            if (i == 0) begin
                n_checks++; if (q_valid !== 1'b0) $display("FAIL decode_latency: got q_valid %b expected 0", q_valid); else n_pass++;
            end else begin
                e = exp_q.pop_front();
                n_checks++; if (q_valid !== 1'b1) $display("FAIL decode_valid_%0d: got %b expected 1", i - 1, q_valid); else n_pass++;
                n_checks++; if (qout !== e) $display("FAIL decode_qout_%0d: got %h expected %h", i - 1, qout, e); else n_pass++;
                n_checks++; if (bout !== e[21]) $display("FAIL decode_bout_%0d: got %b expected %b", i - 1, bout, e[21]); else n_pass++;
            end
        end
        pos_valid = 1'b0;
        tick();
        e = exp_q.pop_front();
        n_checks++; if (q_valid !== 1'b1) $display("FAIL decode_valid_4: got %b expected 1", q_valid); else n_pass++;
        n_checks++; if (qout !== e) $display("FAIL decode_qout_4: got %h expected %h", qout, e); else n_pass++;
        n_checks++; if (bout !== e[21]) $display("FAIL decode_bout_4: got %b expected %b", bout, e[21]); else n_pass++;
        tick();
        n_checks++; if (q_valid !== 1'b0) $display("FAIL decode_empty_valid: got %b expected 0", q_valid); else n_pass++;
        n_checks++; if (qout !== e) $display("FAIL decode_hold: got %h expected %h", qout, e); else n_pass++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL decode_stop_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_backpressure();
        int          codes[5] = '{18, 25, 30, 33, 21};
        logic [21:0] e;
        for (int i = 0; i < 5; i++) begin
            pos_in = 6'(codes[i]);
            pos_valid = 1'b1;
            n_checks++; if (pos_ready !== (i < 4)) $display("FAIL bp_ready_%0d: got %b expected %b", i, pos_ready, (i < 4)); else n_pass++;
            if (i < 4) exp_q.push_back(expect_word(codes[i]));
            tick();
        end
        pos_valid = 1'b0;
        n_checks++; if (ovf !== 1'b1) $display("FAIL bp_ovf: got %b expected 1", ovf); else n_pass++;
        n_checks++; if (q_valid !== 1'b0) $display("FAIL bp_idle_valid: got %b expected 0", q_valid); else n_pass++;
        mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (q_valid !== 1'b0) $display("FAIL bp_start_valid: got %b expected 0", q_valid); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 22'h0;
            n_checks++; if (q_valid !== 1'b1) $display("FAIL bp_valid_%0d: got %b expected 1", i, q_valid); else n_pass++;
            n_checks++; if (qout !== e) $display("FAIL bp_qout_%0d: got %h expected %h", i, qout, e); else n_pass++;
        end
        n_checks++; if (pos_ready !== 1'b1) $display("FAIL bp_ready_after: got %b expected 1", pos_ready); else n_pass++;
        tick();
        n_checks++; if (q_valid !== 1'b0) $display("FAIL bp_fifth_dropped: got q_valid %b expected 0", q_valid); else n_pass++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL bp_stop_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (ovf !== 1'b1) $display("FAIL bp_ovf_sticky: got %b expected 1", ovf); else n_pass++;
    endtask

    task automatic test_sweep();
        int          seq[12] = '{20, 20, 21, 21, 22, 22, 21, 21, 20, 20, 21, 21};
        logic [21:0] e;
        mode = 1'b1;
        sweep_lo = 6'd20;
        sweep_hi = 6'd22;
        sweep_dwell = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            e = expect_word(seq[i]);
            n_checks++; if (q_valid !== 1'b1) $display("FAIL sweep_valid_%0d: got %b expected 1", i, q_valid); else n_pass++;
            n_checks++; if (qout !== e) $display("FAIL sweep_qout_%0d: got %h expected %h", i, qout, e); else n_pass++;
            if (i < 11) tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL sweep_stop_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (q_valid !== 1'b0) $display("FAIL sweep_stop_valid: got %b expected 0", q_valid); else n_pass++;
    endtask

    task automatic test_sweep_hold();
        logic [21:0] e;
        mode = 1'b1;
        sweep_lo = 6'd25;
        sweep_hi = 6'd25;
        sweep_dwell = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e = expect_word(25);
            n_checks++; if (qout !== e) $display("FAIL hold_qout_%0d: got %h expected %h", i, qout, e); else n_pass++;
            if (i < 3) tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL hold_stop_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_start_stop();
        mode = 1'b1;
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL start_stop_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (q_valid !== 1'b0) $display("FAIL start_stop_valid: got %b expected 0", q_valid); else n_pass++;
    endtask

    task automatic test_drain();
        int          codes[3] = '{19, 23, 35};
        int          cnt;
        logic [21:0] e;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            pos_in = 6'(codes[i]);
            pos_valid = 1'b1;
            exp_q.push_back(expect_word(codes[i]));
            tick();
        end
        pos_valid = 1'b0;
        mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        // stop, then a start with sweep mode that must be ignored while busy
        for (int i = 0; i < 10; i++) begin
            stop = (i == 0);
            start = (i == 1);
            mode = 1'b1;
            tick();
            stop = 1'b0;
            start = 1'b0;
            if (q_valid === 1'b1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 22'h0;
                n_checks++; if (qout !== e) $display("FAIL drain_qout_%0d: got %h expected %h", cnt, qout, e); else n_pass++;
                cnt++;
            end
            if (busy !== 1'b1) break;
        end
        n_checks++; if (cnt !== 3) $display("FAIL drain_count: got %0d expected 3", cnt); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL drain_idle: got busy %b expected 0", busy); else n_pass++;
    endtask

`ifdef SKITTER_JITTER_EN
    task automatic test_jitter();
        logic [21:0] e;
        int          m;
        mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i <= 256; i++) begin
            pos_in = 6'd27;
            pos_valid = (i < 256);
            if (i < 256) exp_q.push_back(expect_word(27));
            tick();
            if (i > 0) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 22'h0;
                m = $countones(qout);
                n_checks++; if (qout !== e) $display("FAIL jitter_qout_%0d: got %h expected %h", i - 1, qout, e); else n_pass++;
                n_checks++; if (m < 10 || m > 12) $display("FAIL jitter_m_%0d: got %0d expected 10..12", i - 1, m); else n_pass++;
            end
        end
        pos_valid = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL jitter_stop_busy: got %b expected 0", busy); else n_pass++;
    endtask
`endif

    task automatic test_reset_mid_sweep();
        for (int i = 0; i < 4; i++) begin
            pos_in = 6'(30 + i);
            pos_valid = 1'b1;
            tick();
        end
        pos_valid = 1'b0;
        n_checks++; if (pos_ready !== 1'b0) $display("FAIL rst_mid_full: got %b expected 0", pos_ready); else n_pass++;
        mode = 1'b1;
        sweep_lo = 6'd20;
        sweep_hi = 6'd30;
        sweep_dwell = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL rst_mid_busy_before: got %b expected 1", busy); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (qout !== 22'h0) $display("FAIL rst_mid_qout: got %h expected %h", qout, 22'h0); else n_pass++;
        n_checks++; if (q_valid !== 1'b0) $display("FAIL rst_mid_q_valid: got %b expected 0", q_valid); else n_pass++;
        n_checks++; if (bout !== 1'b0) $display("FAIL rst_mid_bout: got %b expected 0", bout); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL rst_mid_ovf: got %b expected 0", ovf); else n_pass++;
        n_checks++; if (pos_ready !== 1'b1) $display("FAIL rst_mid_pos_ready: got %b expected 1", pos_ready); else n_pass++;
        rst = 1'b0;
        tb_lfsr = 8'hA5;
        exp_q.delete();
        mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_checks++; if (q_valid !== 1'b0) $display("FAIL rst_mid_queue_cleared: got q_valid %b expected 0", q_valid); else n_pass++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_final_busy: got %b expected 0", busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_sweep();
        test_sweep_hold();
        test_start_stop();
        test_drain();
`ifdef SKITTER_JITTER_EN
        test_jitter();
`endif
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
